// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller: load-use hazard detection plus a multi-cycle-op stall FSM.
// Stall/busy/done are combinational from current inputs and state; stall_count is registered.
module pipe_stall_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_reg1_read,
  input  logic [4:0] id_reg1_addr,
  input  logic       id_reg2_read,
  input  logic [4:0] id_reg2_addr,
  input  logic       ex_is_load,
  input  logic       ex_wreg,
  input  logic [4:0] ex_wd,
  input  logic       ex_mc_start,
  input  logic [5:0] ex_mc_cycles,
  input  logic       flush,
  output logic [5:0] stall,
  output logic       mc_busy,
  output logic       mc_done,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [5:0] STALL_MC = 6'b001111;
  localparam logic [5:0] STALL_LU = 6'b000111;

  state_t     state, state_nxt;
  logic [5:0] cnt, cnt_nxt;
  logic       lu;
  logic       accept;
  logic       mc_stall;
  logic [5:0] stall_raw;

  always_comb begin
    lu = ex_is_load & ex_wreg & (ex_wd != 5'd0) &
         ((id_reg1_read & (id_reg1_addr == ex_wd)) |
          (id_reg2_read & (id_reg2_addr == ex_wd)));
  end

  // cnt holds the stall cycles still owed after the current one; RUN always has cnt >= 1.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    mc_stall  = 1'b0;
    case (state)
      RUN: begin
        mc_stall = 1'b1;
        cnt_nxt  = cnt - 6'd1;
        if (cnt == 6'd1) state_nxt = DONE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 6'd0;
        if (ex_mc_start && (ex_mc_cycles != 6'd0) && !flush) begin
          accept    = 1'b1;
          mc_stall  = 1'b1;
          cnt_nxt   = ex_mc_cycles - 6'd1;
          state_nxt = (ex_mc_cycles >= 6'd2) ? RUN : DONE;
        end
      end
    endcase
    if (flush) begin
      state_nxt = IDLE;
      cnt_nxt   = 6'd0;
    end
  end

  always_comb begin
    stall_raw = 6'd0;
    if (flush)         stall_raw = 6'd0;
    else if (mc_stall) stall_raw = STALL_MC;
    else if (lu)       stall_raw = STALL_LU;
  end

  assign stall   = rst ? 6'd0 : stall_raw;
  assign mc_busy = !rst && ((state == RUN) || accept);
  assign mc_done = !rst && (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 6'd0;
      stall_count <= 16'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if ((stall != 6'd0) && (stall_count != 16'hFFFF))
        stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed scenarios plus random traffic against a cycle-debt model.
module tb_pipe_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_reg1_read, id_reg2_read;
  logic [4:0] id_reg1_addr, id_reg2_addr;
  logic       ex_is_load, ex_wreg;
  logic [4:0] ex_wd;
  logic       ex_mc_start;
  logic [5:0] ex_mc_cycles;
  logic       flush;
  logic [5:0] stall;
  logic       mc_busy, mc_done;
  logic [15:0] stall_count;

  int total = 0;
  int bad   = 0;

  // Model: owed = multi-cycle stall cycles still owed after the start cycle,
  // done_due = a release pulse is due this cycle, m_count = expected stall_count.
  int   owed = 0;
  bit   done_due = 1'b0;
  int   m_count = 0;
  bit   m_accept;
  logic [5:0] exp_stall;
  logic       exp_busy, exp_done;
  logic [15:0] exp_count;

  pipe_stall_ctrl dut (
    .clk(clk), .rst(rst),
    .id_reg1_read(id_reg1_read), .id_reg1_addr(id_reg1_addr),
    .id_reg2_read(id_reg2_read), .id_reg2_addr(id_reg2_addr),
    .ex_is_load(ex_is_load), .ex_wreg(ex_wreg), .ex_wd(ex_wd),
    .ex_mc_start(ex_mc_start), .ex_mc_cycles(ex_mc_cycles), .flush(flush),
    .stall(stall), .mc_busy(mc_busy), .mc_done(mc_done), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    rst = 1'b0; id_reg1_read = 1'b0; id_reg1_addr = 5'd0;
    id_reg2_read = 1'b0; id_reg2_addr = 5'd0; ex_is_load = 1'b0;
    ex_wreg = 1'b0; ex_wd = 5'd0; ex_mc_start = 1'b0; ex_mc_cycles = 6'd0;
    flush = 1'b0;
  endtask

  // Let inputs settle mid-cycle and compute expected outputs from the model.
  task automatic settle();
    bit hazard;
    #3;
    hazard = ex_is_load && ex_wreg && (ex_wd != 0) &&
             ((id_reg1_read && id_reg1_addr == ex_wd) ||
              (id_reg2_read && id_reg2_addr == ex_wd));
    m_accept  = !rst && !flush && (owed == 0) && ex_mc_start && (ex_mc_cycles != 0);
    exp_count = 16'(m_count);
    if (rst) begin
      exp_stall = 6'd0; exp_busy = 1'b0; exp_done = 1'b0;
    end else begin
      exp_busy  = (owed > 0) || m_accept;
      exp_done  = done_due;
      if (flush)                      exp_stall = 6'd0;
      else if (owed > 0 || m_accept)  exp_stall = 6'b001111;
      else if (hazard)                exp_stall = 6'b000111;
      else                            exp_stall = 6'd0;
    end
  endtask

  // Advance one clock and update the model with the inputs seen at the edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      owed = 0; done_due = 1'b0; m_count = 0;
    end else begin
      if (exp_stall != 0 && m_count < 65535) m_count++;
      if (flush) begin
        owed = 0; done_due = 1'b0;
      end else if (m_accept) begin
        owed = int'(ex_mc_cycles) - 1; done_due = (ex_mc_cycles == 6'd1);
      end else if (owed > 0) begin
        owed--; done_due = (owed == 0);
      end else begin
        done_due = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    idle_inputs(); rst = 1'b1; ex_mc_start = 1'b1; ex_mc_cycles = 6'd5;
    settle(); tick(); tick();
    settle();
    total++; if (stall !== 6'd0) begin bad++; $display("FAIL reset_stall got=%b want=000000", stall); end
    total++; if (mc_busy !== 1'b0 || mc_done !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b want=00", mc_busy, mc_done); end
    total++; if (stall_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", stall_count); end
    idle_inputs(); settle(); tick();
  endtask

  task automatic test_load_use();
    idle_inputs();
    ex_is_load = 1'b1; ex_wreg = 1'b1; ex_wd = 5'd5; id_reg2_read = 1'b1; id_reg2_addr = 5'd5;
    settle();
    total++; if (stall !== 6'b000111) begin bad++; $display("FAIL lu_hit got=%b want=000111", stall); end
    tick();
    ex_wd = 5'd0; id_reg2_addr = 5'd0;
    settle();
    total++; if (stall !== 6'd0) begin bad++; $display("FAIL lu_r0 got=%b want=000000", stall); end
    tick();
    ex_wd = 5'd7; id_reg2_read = 1'b0; id_reg1_read = 1'b1; id_reg1_addr = 5'd7;
    settle();
    total++; if (stall !== 6'b000111) begin bad++; $display("FAIL lu_src1 got=%b want=000111", stall); end
    tick();
    total++; if (stall_count !== 16'(m_count)) begin bad++; $display("FAIL lu_count got=%0d want=%0d", stall_count, m_count); end
    idle_inputs(); settle(); tick();
  endtask

  task automatic test_multi_cycle_n4();
    logic [5:0] want_s [5] = '{6'b001111, 6'b001111, 6'b001111, 6'b001111, 6'b000000};
    logic       want_d [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    idle_inputs();
    for (int k = 0; k < 6; k++) begin
      ex_mc_start = (k == 0); ex_mc_cycles = (k == 0) ? 6'd4 : 6'd0;
      settle();
      if (k < 5) begin
        total++; if (stall !== want_s[k] || mc_done !== want_d[k])
          begin bad++; $display("FAIL mc4_t%0d got=%b/%b want=%b/%b", k, stall, mc_done, want_s[k], want_d[k]); end
      end else begin
        total++; if (mc_done !== 1'b0 || mc_busy !== 1'b0 || stall !== 6'd0)
          begin bad++; $display("FAIL mc4_idle got=%b/%b/%b want=0/0/000000", stall, mc_busy, mc_done); end
      end
      tick();
    end
  endtask

  task automatic test_boundaries();
    idle_inputs();
    ex_mc_start = 1'b1; ex_mc_cycles = 6'd1; settle();
    total++; if (stall !== 6'b001111 || mc_busy !== 1'b1) begin bad++; $display("FAIL n1_start got=%b/%b want=001111/1", stall, mc_busy); end
    tick(); ex_mc_start = 1'b0; settle();
    total++; if (stall !== 6'd0 || mc_done !== 1'b1) begin bad++; $display("FAIL n1_done got=%b/%b want=000000/1", stall, mc_done); end
    tick();
    ex_mc_start = 1'b1; ex_mc_cycles = 6'd0; settle();
    total++; if (stall !== 6'd0 || mc_busy !== 1'b0) begin bad++; $display("FAIL n0 got=%b/%b want=000000/0", stall, mc_busy); end
    tick(); tick();
    // Back-to-back: N=2 then a new start in its DONE cycle.
    ex_mc_cycles = 6'd2; settle(); tick();
    ex_mc_start = 1'b0; settle(); tick();
    ex_mc_start = 1'b1; ex_mc_cycles = 6'd3; settle();
    total++; if (stall !== 6'b001111 || mc_done !== 1'b1) begin bad++; $display("FAIL b2b_done got=%b/%b want=001111/1", stall, mc_done); end
    tick(); ex_mc_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      settle();
      total++; if (stall !== 6'b001111) begin bad++; $display("FAIL b2b_run%0d got=%b want=001111", k, stall); end
      tick();
    end
    settle();
    total++; if (mc_done !== 1'b1 || stall !== 6'd0) begin bad++; $display("FAIL b2b_end got=%b/%b want=000000/1", stall, mc_done); end
    tick(); idle_inputs(); settle(); tick();
  endtask

  task automatic test_priority();
    idle_inputs();
    ex_mc_start = 1'b1; ex_mc_cycles = 6'd12; settle(); tick();
    ex_mc_start = 1'b0;
    ex_is_load = 1'b1; ex_wreg = 1'b1; ex_wd = 5'd3; id_reg1_read = 1'b1; id_reg1_addr = 5'd3;
    settle();
    total++; if (stall !== 6'b001111) begin bad++; $display("FAIL prio_lu got=%b want=001111", stall); end
    tick();
    flush = 1'b1; settle();
    total++; if (stall !== 6'd0) begin bad++; $display("FAIL flush_now got=%b want=000000", stall); end
    tick(); idle_inputs(); settle();
    total++; if (mc_busy !== 1'b0 || mc_done !== 1'b0 || stall !== 6'd0)
      begin bad++; $display("FAIL flush_next got=%b/%b/%b want=000000/0/0", stall, mc_busy, mc_done); end
    tick();
  endtask

  task automatic test_reset_mid_op();
    int seen_done = 0;
    idle_inputs();
    ex_mc_start = 1'b1; ex_mc_cycles = 6'd10; settle(); tick();
    ex_mc_start = 1'b0; settle(); tick();
    rst = 1'b1; settle();
    total++; if (stall !== 6'd0 || mc_busy !== 1'b0 || mc_done !== 1'b0)
      begin bad++; $display("FAIL rst_mid got=%b/%b/%b want=000000/0/0", stall, mc_busy, mc_done); end
    tick();
    total++; if (stall_count !== 16'd0) begin bad++; $display("FAIL rst_mid_count got=%0d want=0", stall_count); end
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      settle(); if (mc_done !== 1'b0 || stall !== 6'd0) seen_done++; tick();
    end
    total++; if (seen_done != 0) begin bad++; $display("FAIL rst_mid_after got=%0d active cycles want=0", seen_done); end
  endtask

  task automatic test_random();
    int errs = 0;
    idle_inputs();
    for (int k = 0; k < 800; k++) begin
      rst          = ($urandom_range(0, 59) == 0);
      flush        = ($urandom_range(0, 24) == 0);
      ex_is_load   = $urandom_range(0, 1); ex_wreg = $urandom_range(0, 3) != 0;
      ex_wd        = 5'($urandom_range(0, 3));
      id_reg1_read = $urandom_range(0, 1); id_reg1_addr = 5'($urandom_range(0, 3));
      id_reg2_read = $urandom_range(0, 1); id_reg2_addr = 5'($urandom_range(0, 3));
      ex_mc_start  = ($urandom_range(0, 3) == 0);
      ex_mc_cycles = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 4));
      settle();
      total++;
      if (stall !== exp_stall || mc_busy !== exp_busy || mc_done !== exp_done || stall_count !== exp_count) begin
        bad++; errs++;
        if (errs <= 10)
          $display("FAIL rand_c%0d got=%b/%b/%b/%0d want=%b/%b/%b/%0d", k, stall, mc_busy, mc_done,
                   stall_count, exp_stall, exp_busy, exp_done, exp_count);
      end
      tick();
    end
    idle_inputs(); settle(); tick();
  endtask

  task automatic test_saturation();
    idle_inputs();
    ex_is_load = 1'b1; ex_wreg = 1'b1; ex_wd = 5'd9; id_reg1_read = 1'b1; id_reg1_addr = 5'd9;
    for (int k = 0; k < 70000; k++) begin
      settle(); tick();
    end
    settle();
    total++; if (stall_count !== 16'hFFFF) begin bad++; $display("FAIL sat_count got=%h want=ffff", stall_count); end
    total++; if (stall !== 6'b000111) begin bad++; $display("FAIL sat_stall got=%b want=000111", stall); end
    tick(); settle();
    total++; if (stall_count !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h want=ffff", stall_count); end
    idle_inputs(); settle(); tick();
  endtask

  initial begin
    idle_inputs();
    #1;
    test_reset();
    test_load_use();
    test_multi_cycle_n4();
    test_boundaries();
    test_priority();
    test_reset_mid_op();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
